apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

APB slave memory that sits directly downstream of the AHB-to-APB bridge, in the position of the APB peripheral side. It consumes the bridge's `pselx`, `penable`, `pwrite`, `paddr` and `pwdata`, and returns `prdata`. It models three independent peripherals, one per `pselx` bit. Each peripheral has `DEPTH` 32-bit words. The block also has a phase-tracking FSM, a sticky protocol-error flag and transfer counters, so AHB-to-APB traffic can be checked end to end.

## Interface
- `DEPTH`, 16: words per peripheral; must be a power of two, 2 to 256.
- `ADDR_LSB`, 2: lowest `paddr` bit used for the word index; bits below it are ignored.
- `hclk` input 1: system clock; all state changes on its rising edge.
- `hreset` input 1: reset. Asynchronous and active-high: while high, all state is held at its reset value.
- `pselx` input 3: one-hot peripheral select; bit n selects peripheral n.
- `penable` input 1: APB access-phase strobe.
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input 32: word index is `paddr[ADDR_LSB +: log2(DEPTH)]`; all other bits are ignored.
- `pwdata` input 32: write data.
- `prdata` output 32: registered read data. Reset value 0.
- `perr` output 1: sticky protocol-error flag; cleared only by `hreset`. Reset value 0.
- `wr_count` output 16: number of completed writes; wraps from 0xFFFF to 0. Reset value 0.
- `rd_count` output 16: number of completed reads; wraps from 0xFFFF to 0. Reset value 0.

## Operation
- Definitions:
  - `sel` = OR of all `pselx` bits.
  - `idx` = word index taken from `paddr`.
  - `bank` = position of the set bit in `pselx`.
- Storage: 3 × `DEPTH` × 32-bit registers. All are 0 after reset.
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE. Transitions, evaluated at each rising edge:
  - IDLE: `sel`=1 and `penable`=0 → SETUP. `sel`=0 → IDLE. `penable`=1 → IDLE and set `perr`.
  - SETUP: `sel`=1 and `penable`=1 → ACCESS. `penable`=0 → SETUP (setup phase extended, no error). `sel`=0 → IDLE and set `perr`.
  - ACCESS: `sel`=1 and `penable`=0 → SETUP (back-to-back transfer). `sel`=0 → IDLE. `penable`=1 → ACCESS and set `perr`; no second commit.
- Address and control capture:
  - On each edge that enters SETUP, latch `pselx`, `idx` and `pwrite`.
  - If the access phase presents `pselx`, `paddr` word index or `pwrite` different from the latched values, set `perr`. The transfer still completes using the latched values.
  - Set `perr` whenever `pselx` has more than one bit set. While it does, no write commits and no counter increments.
- Read path:
  - On the edge entering SETUP with `pwrite`=0, load `prdata` from memory at `bank`/`idx`.
  - `prdata` holds that value through the following ACCESS cycle.
  - `prdata` is otherwise unchanged, and keeps its last value in IDLE.
- Write path: on the SETUP→ACCESS edge with the latched `pwrite`=1, write `pwdata` to the latched `bank`/`idx`.
- Counters: on the SETUP→ACCESS edge, increment `wr_count` (writes) or `rd_count` (reads) by 1, with 16-bit wrap.
- `pwdata` is don't-care on reads.

## Timing
- A transfer is 2 cycles minimum: SETUP then ACCESS. Back-to-back transfers cost 2 cycles each, with no IDLE in between.
- Read data is valid at the start of the ACCESS cycle, one edge after SETUP is sampled. It remains stable until the next SETUP edge of a read.
- Write data is visible in memory after the SETUP→ACCESS edge.
- Write then read to the same address, back to back: the read's SETUP edge is one edge after the write commits, so it returns the new data. There is no bypass logic.
- Asserting `hreset` mid-transfer:
  - The FSM goes to IDLE immediately.
  - Memory, `prdata`, `perr` and the counters clear.
  - An uncommitted write is lost.
- Deasserting `hreset`: the first edge after release is evaluated from IDLE.

## Test plan
- Reset, then idle for 3 cycles:
  - Required: `prdata`=0, `perr`=0, `wr_count`=0, `rd_count`=0.
  - Read of `pselx`=3'b001, `paddr`=0x8 returns 0.
- Write `pselx`=3'b010, `paddr`=0x0C, `pwdata`=0xDEADBEEF, then a back-to-back read of the same address:
  - `prdata`=0xDEADBEEF during the read's ACCESS cycle.
  - `wr_count`=1, `rd_count`=1.
  - Reading `pselx`=3'b001, `paddr`=0x0C still returns 0 (banks are independent).
- Four writes to `pselx`=3'b100 at word indices 0 to 3 (`paddr`=0x00, 0x04, 0x08, 0x0C), data 0x11, 0x22, 0x33, 0x44, then four reads in reverse index order:
  - Reads return 0x44, 0x33, 0x22, 0x11.
  - `wr_count`=4, `rd_count`=4.
- Address aliasing with `DEPTH`=16: write 0xA5 at `paddr`=0x40 (word index wraps to 0), then read `paddr`=0x00 → 0xA5.
- Protocol errors, each preceded by a fresh reset:
  - `penable`=1 while IDLE → `perr`=1.
  - `pselx`=3'b011 in SETUP → `perr`=1, no memory change, counters unchanged.
  - `paddr` changed between SETUP and ACCESS → `perr`=1, write lands at the SETUP address.
- Reset mid-write: assert `hreset` during the SETUP cycle of a write of 0x55 to `pselx`=3'b001, `paddr`=0x4. After release, reading that address returns 0 and `wr_count`=0.

Source files
------------

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB slave memory: three peripheral banks, phase FSM, protocol-error flag, transfer counters
//
// Ports:
//   hclk      in   1   system clock, rising edge
//   hreset    in   1   asynchronous active-high reset
//   pselx     in   3   one-hot peripheral select (bit n = bank n)
//   penable   in   1   APB access-phase strobe
//   pwrite    in   1   1 = write, 0 = read
//   paddr     in  32   word index = paddr[ADDR_LSB +: log2(DEPTH)]
//   pwdata    in  32   write data
//   prdata    out 32   registered read data
//   perr      out  1   sticky protocol-error flag
//   wr_count  out 16   completed writes (wrapping)
//   rd_count  out 16   completed reads (wrapping)
module apb_slave_mem #(
    parameter int DEPTH    = 16,
    parameter int ADDR_LSB = 2
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [2:0]  pselx,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        perr,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   mem_q [3][DEPTH];
    logic [2:0]    lat_sel_q;
    logic [AW-1:0] lat_idx_q;
    logic          lat_wr_q;
    logic [31:0]   prdata_q;
    logic          perr_q;
    logic [15:0]   wr_count_q;
    logic [15:0]   rd_count_q;

    logic          sel;
    logic          multi;
    logic          lat_multi;
    logic [AW-1:0] idx;
    logic          mismatch;
    logic          err_set;
    logic          latch;
    logic          commit;
    logic          commit_ok;
    logic [31:0]   rd_word;
    logic          unused_paddr;

    assign sel       = |pselx;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi     = (pselx & (pselx - 3'd1)) != 3'd0;
    assign lat_multi = (lat_sel_q & (lat_sel_q - 3'd1)) != 3'd0;
    assign idx       = paddr[ADDR_LSB +: AW];
    assign mismatch  = (pselx != lat_sel_q) || (idx != lat_idx_q) || (pwrite != lat_wr_q);
    // A multi-select in either phase suppresses the commit entirely.
    assign commit_ok = commit && !multi && !lat_multi;
    assign unused_paddr = ^paddr;

    // One-hot read mux; an all-zero select yields zero.
    always_comb begin
        rd_word = '0;
        for (int b = 0; b < 3; b++) begin
            if (pselx[b]) rd_word = rd_word | mem_q[b][idx];
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        err_set = multi;
        latch   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (penable) begin
                    err_set = 1'b1;
                end else if (sel) begin
                    state_d = ST_SETUP;
                    latch   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (!sel) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                end else if (penable) begin
                    state_d = ST_ACCESS;
                    commit  = 1'b1;
                    if (mismatch) err_set = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!sel) begin
                    state_d = ST_IDLE;
                end else if (penable) begin
                    // Stuck access phase: flag it, but never commit twice.
                    err_set = 1'b1;
                end else begin
                    state_d = ST_SETUP;
                    latch   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int b = 0; b < 3; b++) begin
                for (int w = 0; w < DEPTH; w++) begin
                    mem_q[b][w] <= '0;
                end
            end
            lat_sel_q  <= '0;
            lat_idx_q  <= '0;
            lat_wr_q   <= 1'b0;
            prdata_q   <= '0;
            perr_q     <= 1'b0;
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            if (latch) begin
                lat_sel_q <= pselx;
                lat_idx_q <= idx;
                lat_wr_q  <= pwrite;
                if (!pwrite && !multi) prdata_q <= rd_word;
            end
            if (commit_ok && lat_wr_q) begin
                for (int b = 0; b < 3; b++) begin
                    if (lat_sel_q[b]) mem_q[b][lat_idx_q] <= pwdata;
                end
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (commit_ok && !lat_wr_q) rd_count_q <= rd_count_q + 16'd1;
            if (err_set) perr_q <= 1'b1;
        end
    end

    assign prdata   = prdata_q;
    assign perr     = perr_q;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - scoreboard testbench for apb_slave_mem
module tb_apb_slave_mem;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic [2:0]  pselx = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        perr;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    apb_slave_mem #(.DEPTH(16), .ADDR_LSB(2)) dut (
        .hclk     (hclk),
        .hreset   (hreset),
        .pselx    (pselx),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .perr     (perr),
        .wr_count (wr_count),
        .rd_count (rd_count)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read access phase is the moment prdata must carry the expected word.
    always @(negedge hclk) begin
        if (!hreset && (pselx != 3'b000) && penable && !pwrite) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL read_unexpected: got %h expected none", prdata);
            end else begin
                chk("read_data", prdata, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        hreset  = 1'b1;
        pselx   = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
    endtask

    task automatic apb(input logic [2:0] s, input logic [31:0] a, input logic w, input logic [31:0] d);
        @(posedge hclk);
        #1;
        pselx   = s;
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        penable = 1'b0;
        @(posedge hclk);
        #1 penable = 1'b1;
    endtask

    task automatic wr(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        apb(s, a, 1'b1, d);
    endtask

    task automatic rd(input logic [2:0] s, input logic [31:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        apb(s, a, 1'b0, 32'h0);
    endtask

    task automatic idle();
        @(posedge hclk);
        #1;
        pselx   = '0;
        penable = 1'b0;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        repeat (3) @(posedge hclk);
        #1;
        chk("reset_prdata", prdata, 32'h0);
        chk("reset_perr", {31'h0, perr}, 32'h0);
        chk("reset_wr_count", {16'h0, wr_count}, 32'h0);
        chk("reset_rd_count", {16'h0, rd_count}, 32'h0);
        rd(3'b001, 32'h8, 32'h0);
        idle();

        // Write then back-to-back read, bank independence
        do_reset();
        wr(3'b010, 32'h0C, 32'hDEADBEEF);
        rd(3'b010, 32'h0C, 32'hDEADBEEF);
        idle();
        chk("wr_then_rd_wr_count", {16'h0, wr_count}, 32'd1);
        chk("wr_then_rd_rd_count", {16'h0, rd_count}, 32'd1);
        chk("prdata_holds_idle", prdata, 32'hDEADBEEF);
        rd(3'b001, 32'h0C, 32'h0);
        idle();
        chk("no_err_clean", {31'h0, perr}, 32'h0);

        // Four writes then reverse-order reads
        do_reset();
        wr(3'b100, 32'h00, 32'h11);
        wr(3'b100, 32'h04, 32'h22);
        wr(3'b100, 32'h08, 32'h33);
        wr(3'b100, 32'h0C, 32'h44);
        rd(3'b100, 32'h0C, 32'h44);
        rd(3'b100, 32'h08, 32'h33);
        rd(3'b100, 32'h04, 32'h22);
        rd(3'b100, 32'h00, 32'h11);
        idle();
        chk("burst_wr_count", {16'h0, wr_count}, 32'd4);
        chk("burst_rd_count", {16'h0, rd_count}, 32'd4);

        // Address aliasing: 0x40 wraps to word 0
        wr(3'b001, 32'h40, 32'hA5);
        rd(3'b001, 32'h00, 32'hA5);
        idle();

        // penable while idle
        do_reset();
        @(posedge hclk);
        #1 penable = 1'b1;
        @(posedge hclk);
        #1 penable = 1'b0;
        chk("err_penable_idle", {31'h0, perr}, 32'd1);

        // Multi-bit select
        do_reset();
        wr(3'b011, 32'h00, 32'h77);
        idle();
        chk("err_multisel", {31'h0, perr}, 32'd1);
        chk("multisel_wr_count", {16'h0, wr_count}, 32'd0);
        chk("multisel_rd_count", {16'h0, rd_count}, 32'd0);
        rd(3'b001, 32'h00, 32'h0);
        rd(3'b010, 32'h00, 32'h0);
        idle();

        // Address changes between setup and access
        do_reset();
        @(posedge hclk);
        #1;
        pselx  = 3'b001;
        paddr  = 32'h4;
        pwrite = 1'b1;
        pwdata = 32'h99;
        @(posedge hclk);
        #1;
        penable = 1'b1;
        paddr   = 32'h8;
        idle();
        chk("err_addr_change", {31'h0, perr}, 32'd1);
        chk("addr_change_wr_count", {16'h0, wr_count}, 32'd1);
        rd(3'b001, 32'h4, 32'h99);
        rd(3'b001, 32'h8, 32'h0);
        idle();

        // Reset during the setup phase of a write
        do_reset();
        @(posedge hclk);
        #1;
        pselx   = 3'b001;
        paddr   = 32'h4;
        pwrite  = 1'b1;
        pwdata  = 32'h55;
        penable = 1'b0;
        #3 hreset = 1'b1;
        pselx = '0;
        @(posedge hclk);
        #1 hreset = 1'b0;
        rd(3'b001, 32'h4, 32'h0);
        idle();
        chk("rst_mid_wr_count", {16'h0, wr_count}, 32'd0);
        chk("rst_mid_rd_count", {16'h0, rd_count}, 32'd1);

        repeat (2) @(posedge hclk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
